// File: rtl/pe_packet_injector_if.sv
// Signal bundle between the local PE, the packet injector and the router PE input port.
// The injector uses the slave view; whatever drives requests and absorbs packets uses master.
interface pe_packet_injector_if;
  logic        sendReq;
  logic [7:0]  sendDestX;
  logic [7:0]  sendDestY;
  logic [31:0] sendPayload;
  logic        sendReady;
  logic        errOut;
  logic        reqOut;
  logic [63:0] dataOut;
  logic        readyIn;
  logic [15:0] pktSentCount;

  modport master (
    output sendReq, sendDestX, sendDestY, sendPayload, readyIn,
    input  sendReady, errOut, reqOut, dataOut, pktSentCount
  );

  modport slave (
    input  sendReq, sendDestX, sendDestY, sendPayload, readyIn,
    output sendReady, errOut, reqOut, dataOut, pktSentCount
  );
endinterface

// File: rtl/pe_packet_injector.sv
// PE-side transmitter: encodes send requests into 64-bit routed packets, buffers them
// in a small circular FIFO and hands them to the router through a req/ready output register.
module pe_packet_injector #(
  parameter int          DATA_WIDTH      = 64,
  parameter logic [15:0] CURRENT_ADDRESS = 16'h0000,
  parameter int          MESH_X          = 4,
  parameter int          MESH_Y          = 4,
  parameter int          FIFO_DEPTH      = 4
) (
  input logic                clk,
  input logic                reset,
  pe_packet_injector_if.slave pe
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [7:0]    SRC_X    = CURRENT_ADDRESS[15:8];
  localparam logic [7:0]    SRC_Y    = CURRENT_ADDRESS[7:0];
  localparam logic [8:0]    MESH_X_L = 9'(MESH_X);
  localparam logic [8:0]    MESH_Y_L = 9'(MESH_Y);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic [4:0]            seq_q;
  state_t                state_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  err_q;
  logic [15:0]           sent_q;

  logic                  dir_x, dir_y, in_range;
  logic [3:0]            hop_x, hop_y;
  logic [DATA_WIDTH-1:0] packet_enc;
  logic                  send_ready, accept, push, pop, fifo_nempty;

  // Magnitudes come from a 9-bit difference; the range check keeps them within 4 bits.
  always_comb begin
    dir_x      = (pe.sendDestX >= SRC_X);
    dir_y      = (pe.sendDestY >= SRC_Y);
    hop_x      = dir_x ? 4'({1'b0, pe.sendDestX} - {1'b0, SRC_X})
                       : 4'({1'b0, SRC_X} - {1'b0, pe.sendDestX});
    hop_y      = dir_y ? 4'({1'b0, pe.sendDestY} - {1'b0, SRC_Y})
                       : 4'({1'b0, SRC_Y} - {1'b0, pe.sendDestY});
    in_range   = ({1'b0, pe.sendDestX} < MESH_X_L) && ({1'b0, pe.sendDestY} < MESH_Y_L);
    packet_enc = {1'b0, dir_x, dir_y, seq_q, hop_x, hop_y, SRC_X, SRC_Y, pe.sendPayload};
  end

  // No write-through: a full FIFO refuses requests even while it is being popped.
  assign send_ready  = (count_q != FULL_CNT);
  assign fifo_nempty = (count_q != '0);
  assign accept      = pe.sendReq && send_ready;
  assign push        = accept && in_range;
  assign pop         = fifo_nempty && ((state_q == S_EMPTY) || pe.readyIn);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= packet_enc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      seq_q    <= '0;
      state_q  <= S_EMPTY;
      data_q   <= '0;
      err_q    <= 1'b0;
      sent_q   <= '0;
    end else begin
      count_q <= count_d;
      err_q   <= accept && !in_range;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        seq_q    <= seq_q + 5'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case (state_q)
        S_EMPTY: begin
          if (fifo_nempty) begin
            data_q  <= mem_q[rd_ptr_q];
            state_q <= S_FULL;
          end
        end
        S_FULL: begin
          // dataOut only moves once the router has taken the current packet.
          if (pe.readyIn) begin
            sent_q <= sent_q + 16'd1;
            if (fifo_nempty) begin
              data_q <= mem_q[rd_ptr_q];
            end else begin
              state_q <= S_EMPTY;
            end
          end
        end
        default: state_q <= S_EMPTY;
      endcase
    end
  end

  assign pe.sendReady    = send_ready;
  assign pe.errOut       = err_q;
  assign pe.reqOut       = (state_q == S_FULL);
  assign pe.dataOut      = data_q;
  assign pe.pktSentCount = sent_q;

endmodule

// File: tb/tb_pe_packet_injector.sv
// Randomized bench for pe_packet_injector: packets are predicted from the header rules
// and compared in order against every router handshake seen on the output port.
module tb_pe_packet_injector;
  localparam logic [15:0] ADDR  = 16'h0101;
  localparam int          MX    = 4;
  localparam int          MY    = 4;
  localparam int          DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pe_packet_injector_if bus();

  pe_packet_injector #(
    .DATA_WIDTH(64), .CURRENT_ADDRESS(ADDR), .MESH_X(MX), .MESH_Y(MY), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pe(bus)
  );

  int tests_run = 0;
  int tests_failed = 0;
  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];
  int model_seq = 0;
  int exp_sent = 0;

  // Handshake completes at the coming edge when req and ready are both up and reset is released.
  always @(negedge clk) begin
    if (reset && bus.reqOut === 1'b1 && bus.readyIn === 1'b1) obs_q.push_back(bus.dataOut);
  end

  function automatic logic [63:0] model_pkt(input int x, input int y, input int seq,
                                            input logic [31:0] p);
    int   sx;
    int   sy;
    int   hx;
    int   hy;
    logic dx;
    logic dy;
    sx = int'(ADDR[15:8]);
    sy = int'(ADDR[7:0]);
    dx = (x >= sx);
    dy = (y >= sy);
    hx = (x >= sx) ? (x - sx) : (sx - x);
    hy = (y >= sy) ? (y - sy) : (sy - y);
    return {1'b0, dx, dy, 5'(seq % 32), 4'(hx), 4'(hy), ADDR, p};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int x, input int y, input logic [31:0] p, output bit acc);
    bit bad;
    bus.sendReq     = 1'b1;
    bus.sendDestX   = 8'(x);
    bus.sendDestY   = 8'(y);
    bus.sendPayload = p;
    acc = bus.sendReady;
    bad = (x >= MX) || (y >= MY);
    if (acc && !bad) begin
      exp_q.push_back(model_pkt(x, y, model_seq, p));
      model_seq = (model_seq + 1) % 32;
    end
    tick(1);
    bus.sendReq = 1'b0;
  endtask

  task automatic do_reset();
    bus.sendReq = 1'b0;
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    exp_q.delete();
    obs_q.delete();
    model_seq = 0;
    exp_sent = 0;
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (obs_q.size() >= exp_q.size() && bus.reqOut === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic test_reset();
    tick(2);
    do_reset();
    tests_run++; if (bus.reqOut !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %b expected 0", bus.reqOut); end
    tests_run++; if (bus.dataOut !== 64'h0) begin tests_failed++; $display("FAIL reset_data: got %h expected 0", bus.dataOut); end
    tests_run++; if (bus.errOut !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b expected 0", bus.errOut); end
    tests_run++; if (bus.sendReady !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b expected 1", bus.sendReady); end
    tests_run++; if (bus.pktSentCount !== 16'd0) begin tests_failed++; $display("FAIL reset_count: got %0d expected 0", bus.pktSentCount); end
  endtask

  task automatic test_basic();
    bit acc;
    bit ok;
    logic [63:0] e;
    logic [63:0] o;
    bus.readyIn = 1'b1;
    send(3, 0, 32'hDEADBEEF, acc);
    tests_run++; if (bus.reqOut !== 1'b0) begin tests_failed++; $display("FAIL basic_latency1: reqOut got %b expected 0", bus.reqOut); end
    tick(1);
    tests_run++; if (bus.reqOut !== 1'b1) begin tests_failed++; $display("FAIL basic_latency2: reqOut got %b expected 1", bus.reqOut); end
    tests_run++; if (bus.dataOut !== 64'h40210101DEADBEEF) begin tests_failed++; $display("FAIL basic_pkt0: got %h expected 40210101deadbeef", bus.dataOut); end
    tick(1);
    tests_run++; if (bus.pktSentCount !== 16'd1) begin tests_failed++; $display("FAIL basic_count1: got %0d expected 1", bus.pktSentCount); end
    send(0, 2, 32'h12345678, acc);
    tick(1);
    tests_run++; if (bus.dataOut !== 64'h2111010112345678) begin tests_failed++; $display("FAIL basic_pkt1: got %h expected 2111010112345678", bus.dataOut); end
    wait_drain(20, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL basic_drain: got timeout expected drained"); end
    exp_sent += exp_q.size();
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      $display("[TB] basic pkt data=%h", o);
      tests_run++; if (o !== e) begin tests_failed++; $display("FAIL basic_order: got %h expected %h", o, e); end
    end
    tests_run++; if (bus.pktSentCount !== 16'(exp_sent)) begin tests_failed++; $display("FAIL basic_count2: got %0d expected %0d", bus.pktSentCount, exp_sent); end
  endtask

  task automatic test_self_error();
    bit acc;
    bit ok;
    logic [63:0] e;
    logic [63:0] o;
    bus.readyIn = 1'b1;
    send(1, 1, 32'hA5A5_0001, acc);
    tests_run++; if (bus.errOut !== 1'b0) begin tests_failed++; $display("FAIL self_err: got %b expected 0", bus.errOut); end
    send(4, 0, 32'hBAD0_0004, acc);
    tests_run++; if (bus.errOut !== 1'b1) begin tests_failed++; $display("FAIL err_x_pulse: got %b expected 1", bus.errOut); end
    tick(1);
    tests_run++; if (bus.errOut !== 1'b0) begin tests_failed++; $display("FAIL err_x_width: got %b expected 0", bus.errOut); end
    send(0, 7, 32'hBAD0_0007, acc);
    tests_run++; if (bus.errOut !== 1'b1) begin tests_failed++; $display("FAIL err_y_pulse: got %b expected 1", bus.errOut); end
    send(2, 3, 32'hC0DE_0023, acc);
    tests_run++; if (bus.errOut !== 1'b0) begin tests_failed++; $display("FAIL err_clear: got %b expected 0", bus.errOut); end
    wait_drain(20, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL self_drain: got timeout expected drained"); end
    tests_run++; if (obs_q.size() !== 2) begin tests_failed++; $display("FAIL self_pkts: got %0d packets expected 2", obs_q.size()); end
    if (obs_q.size() > 0) begin
      o = obs_q[0];
      tests_run++; if (o[62:61] !== 2'b11 || o[55:48] !== 8'h00) begin tests_failed++; $display("FAIL self_fields: got dir=%b hop=%h expected dir=11 hop=00", o[62:61], o[55:48]); end
    end
    exp_sent += exp_q.size();
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      $display("[TB] self/err pkt data=%h", o);
      tests_run++; if (o !== e) begin tests_failed++; $display("FAIL self_order: got %h expected %h", o, e); end
    end
    tests_run++; if (bus.pktSentCount !== 16'(exp_sent)) begin tests_failed++; $display("FAIL self_count: got %0d expected %0d", bus.pktSentCount, exp_sent); end
  endtask

  task automatic test_back_to_back();
    bit acc;
    int accepted;
    logic [63:0] held;
    logic [63:0] e;
    logic [63:0] o;
    bus.readyIn = 1'b0;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      send(int'($urandom_range(0, MX - 1)), int'($urandom_range(0, MY - 1)), $urandom, acc);
      accepted += int'(acc);
    end
    tests_run++; if (accepted !== 5) begin tests_failed++; $display("FAIL stall_accepted: got %0d expected 5", accepted); end
    tests_run++; if (bus.sendReady !== 1'b0) begin tests_failed++; $display("FAIL stall_ready: got %b expected 0", bus.sendReady); end
    tests_run++; if (bus.reqOut !== 1'b1) begin tests_failed++; $display("FAIL stall_req: got %b expected 1", bus.reqOut); end
    tests_run++; if (exp_q.size() == 0 || bus.dataOut !== exp_q[0]) begin tests_failed++; $display("FAIL stall_head: got %h expected first queued packet", bus.dataOut); end
    held = bus.dataOut;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      tests_run++; if (bus.dataOut !== held) begin tests_failed++; $display("FAIL stall_stable: got %h expected %h", bus.dataOut, held); end
    end
    bus.readyIn = 1'b1;
    tick(5);
    tests_run++; if (obs_q.size() !== 5) begin tests_failed++; $display("FAIL burst_len: got %0d packets in 5 cycles expected 5", obs_q.size()); end
    tests_run++; if (bus.reqOut !== 1'b0) begin tests_failed++; $display("FAIL burst_end: reqOut got %b expected 0", bus.reqOut); end
    exp_sent += exp_q.size();
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      $display("[TB] burst pkt data=%h", o);
      tests_run++; if (o !== e) begin tests_failed++; $display("FAIL burst_order: got %h expected %h", o, e); end
    end
    tests_run++; if (bus.pktSentCount !== 16'(exp_sent)) begin tests_failed++; $display("FAIL burst_count: got %0d expected %0d", bus.pktSentCount, exp_sent); end
  endtask

  task automatic test_seq_wrap();
    bit acc;
    bit ok;
    logic [63:0] e;
    logic [63:0] o;
    do_reset();
    bus.readyIn = 1'b1;
    for (int i = 0; i < 33; i++) begin
      send(int'($urandom_range(0, MX - 1)), int'($urandom_range(0, MY - 1)), $urandom, acc);
    end
    wait_drain(60, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL wrap_drain: got timeout expected drained"); end
    tests_run++; if (obs_q.size() !== 33) begin tests_failed++; $display("FAIL wrap_pkts: got %0d expected 33", obs_q.size()); end
    exp_sent += exp_q.size();
    for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      $display("[TB] wrap pkt %0d data=%h", i, o);
      tests_run++; if (o !== e) begin tests_failed++; $display("FAIL wrap_pkt: got %h expected %h", o, e); end
      tests_run++; if (o[60:56] !== 5'(i % 32)) begin tests_failed++; $display("FAIL wrap_seq: got %0d expected %0d", o[60:56], i % 32); end
    end
    tests_run++; if (bus.pktSentCount !== 16'd33) begin tests_failed++; $display("FAIL wrap_count: got %0d expected 33", bus.pktSentCount); end
  endtask

  task automatic test_random();
    bit acc;
    bit ok;
    bit bad;
    int x;
    int y;
    logic [63:0] e;
    logic [63:0] o;
    for (int i = 0; i < 300; i++) begin
      bus.readyIn = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 1) == 1) begin
        x = int'($urandom_range(0, MX + 1));
        y = int'($urandom_range(0, MY + 1));
        bad = (x >= MX) || (y >= MY);
        send(x, y, $urandom, acc);
        tests_run++; if (bus.errOut !== (acc && bad)) begin tests_failed++; $display("FAIL rand_err: got %b expected %b", bus.errOut, acc && bad); end
      end else begin
        tick(1);
      end
    end
    bus.readyIn = 1'b1;
    wait_drain(40, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL rand_drain: got timeout expected drained"); end
    tests_run++; if (obs_q.size() !== exp_q.size()) begin tests_failed++; $display("FAIL rand_pkts: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    exp_sent += exp_q.size();
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      $display("[TB] rand pkt data=%h", o);
      tests_run++; if (o !== e) begin tests_failed++; $display("FAIL rand_pkt: got %h expected %h", o, e); end
    end
    tests_run++; if (bus.pktSentCount !== 16'(exp_sent)) begin tests_failed++; $display("FAIL rand_count: got %0d expected %0d", bus.pktSentCount, exp_sent); end
  endtask

  task automatic test_reset_mid();
    bit acc;
    bit ok;
    logic [63:0] e;
    logic [63:0] o;
    bus.readyIn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(int'($urandom_range(0, MX - 1)), int'($urandom_range(0, MY - 1)), $urandom, acc);
    end
    tests_run++; if (bus.reqOut !== 1'b1) begin tests_failed++; $display("FAIL mid_pre_req: got %b expected 1", bus.reqOut); end
    do_reset();
    tests_run++; if (bus.reqOut !== 1'b0) begin tests_failed++; $display("FAIL mid_req: got %b expected 0", bus.reqOut); end
    tests_run++; if (bus.sendReady !== 1'b1) begin tests_failed++; $display("FAIL mid_ready: got %b expected 1", bus.sendReady); end
    tests_run++; if (bus.pktSentCount !== 16'd0) begin tests_failed++; $display("FAIL mid_count: got %0d expected 0", bus.pktSentCount); end
    tests_run++; if (bus.dataOut !== 64'h0) begin tests_failed++; $display("FAIL mid_data: got %h expected 0", bus.dataOut); end
    bus.readyIn = 1'b1;
    send(2, 2, 32'h0BADF00D, acc);
    wait_drain(20, ok);
    tick(5);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL mid_drain: got timeout expected drained"); end
    tests_run++; if (obs_q.size() !== 1) begin tests_failed++; $display("FAIL mid_stale: got %0d packets expected 1", obs_q.size()); end
    exp_sent += exp_q.size();
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      $display("[TB] post-reset pkt data=%h", o);
      tests_run++; if (o !== e) begin tests_failed++; $display("FAIL mid_pkt: got %h expected %h", o, e); end
      tests_run++; if (o[60:56] !== 5'd0) begin tests_failed++; $display("FAIL mid_seq: got %0d expected 0", o[60:56]); end
    end
    tests_run++; if (bus.pktSentCount !== 16'(exp_sent)) begin tests_failed++; $display("FAIL mid_count2: got %0d expected %0d", bus.pktSentCount, exp_sent); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.sendReq     = 1'b0;
    bus.sendDestX   = 8'h0;
    bus.sendDestY   = 8'h0;
    bus.sendPayload = 32'h0;
    bus.readyIn     = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_self_error();
    test_back_to_back();
    test_seq_wrap();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/pe_packet_injector.md
Name: pe_packet_injector

Overview:
PE-side network interface transmitter. It is the encoder counterpart of the router's per-input routing decoder. It accepts send requests (destination x/y plus 32-bit payload) from the local PE and builds the 64-bit packet header: direction bits, hop counts, source address and sequence number. Packets are buffered in a small FIFO and injected into the router's PE input port over a req/ready handshake.

Parameters:
DATA_WIDTH, 64, packet width; fixed at 64 by the header layout.
CURRENT_ADDRESS, 16'h0000, this node's address; x in [15:8], y in [7:0].
MESH_X, 4, mesh columns; valid destination x is 0..MESH_X-1.
MESH_Y, 4, mesh rows; valid destination y is 0..MESH_Y-1.
FIFO_DEPTH, 4, number of packet buffer entries (power of 2, at least 2).

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-low reset.
sendReq  in  1  PE send request.
sendDestX  in  8  destination x.
sendDestY  in  8  destination y.
sendPayload  in  32  payload, placed in packet bits [31:0].
sendReady  out  1  high when the PE request can be accepted; equals !fifo_full.
errOut  out  1  one-cycle pulse when an accepted request is dropped because its destination is out of range.
reqOut  out  1  packet valid toward the router PE input.
dataOut  out  64  packet toward the router.
readyIn  in  1  router can accept a packet.
pktSentCount  out  16  number of completed router handshakes; wraps.

Behaviour:
- Packet layout:
  - bit 63 = 0.
  - bit 62 dir_x = (destX >= srcX).
  - bit 61 dir_y = (destY >= srcY).
  - [60:56] = 5-bit sequence number.
  - [55:52] hop_x = |destX - srcX|.
  - [51:48] hop_y = |destY - srcY|.
  - [47:40] = CURRENT_ADDRESS[15:8].
  - [39:32] = CURRENT_ADDRESS[7:0].
  - [31:0] = payload.
- Arithmetic: differences are computed in 9 bits and the magnitude is truncated to 4 bits. The range check guarantees the magnitude is at most 15 whenever MESH_X and MESH_Y are at most 16.
- Self-destination (dest == current address) is legal: dir_x = dir_y = 1, hop_x = hop_y = 0.
- Accept: a request is accepted at a rising edge when sendReq && sendReady.
  - Destination in range: the fully encoded packet is written to the FIFO tail, and seq increments (31 wraps to 0).
  - destX >= MESH_X or destY >= MESH_Y: nothing is written, seq is unchanged, and errOut is high for exactly the following cycle.
- FIFO: circular buffer with read/write pointers and an occupancy count.
  - Simultaneous read and write keeps the count unchanged.
  - There is no write-through when full: sendReady is low whenever count == FIFO_DEPTH, even if a pop happens in the same cycle.
- Output stage: a single register (reqOut/dataOut) driven by a 2-state FSM.
  - EMPTY: reqOut = 0. If the FIFO is non-empty, pop the head into dataOut and go to FULL.
  - FULL: reqOut = 1, and dataOut is held stable while readyIn = 0.
    - On readyIn = 1: the handshake completes and pktSentCount increments. If the FIFO is non-empty in that cycle, pop the next head and stay FULL (back-to-back, one packet per cycle). Otherwise go to EMPTY.
- Latency: a request accepted at edge k with an empty pipeline gives reqOut = 1 after edge k+1.
  - Ordering is strict FIFO; no packet is reordered or duplicated.
- readyIn is ignored while reqOut = 0.
- Reset (reset = 0 at an edge), including mid-transfer, applies all of the following:
  - FIFO is emptied and pointers/count go to 0.
  - seq = 0 and the FSM goes to EMPTY.
  - reqOut = 0, dataOut = 0, errOut = 0, pktSentCount = 0.
  - sendReady = 1 from the first cycle after reset.
  - Any in-flight packet is discarded.

Test Plan:
1. CURRENT_ADDRESS = 16'h0101, 4x4 mesh, readyIn = 1; send dest (3,0), payload 32'hDEADBEEF -> reqOut high after 2 edges, dataOut = 64'h40210101DEADBEEF, pktSentCount = 1.
2. Next send dest (0,2), payload 32'h12345678 -> dataOut = 64'h2111010112345678 (seq = 1, dir_x = 0, dir_y = 1).
3. Self-send dest (1,1) -> dir_x = dir_y = 1 and hop fields 0; send dest (4,0) -> no packet, errOut pulses 1 cycle, and the next good packet's seq is not skipped.
4. readyIn = 0, six back-to-back sends -> 5 accepted (4 in FIFO + 1 in output register), sendReady low after the 5th; dataOut is stable while stalled. Raise readyIn -> 5 packets in order on consecutive cycles, pktSentCount = 5.
5. Send 33 good packets -> seq field walks 0..31 then 0; pktSentCount = 33.
6. Assert reset while reqOut = 1 with 3 entries queued -> next cycle reqOut = 0, sendReady = 1, pktSentCount = 0; the first packet after reset carries seq = 0.
